// File: rtl/traffic_pkg.sv
// Shared light codes, phase encoding and phase-to-lamp decode for the intersection scheduler.
// Latency: purely combinational helpers, no state.
// Backpressure: none; lamp drivers consume the decoded codes every cycle.
package traffic_pkg;

  // Lamp codes shared with the existing lamp-driver front-end.
  localparam logic [1:0] GREEN  = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] RED    = 2'b10;

  // Phase codes are visible on the debug port, so their values are fixed.
  typedef enum logic [2:0] {
    A_GREEN  = 3'd0,
    A_YELLOW = 3'd1,
    RED_AB   = 3'd2,
    B_GREEN  = 3'd3,
    B_YELLOW = 3'd4,
    RED_BA   = 3'd5
  } phase_t;

  typedef struct packed {
    logic [1:0] la;
    logic [1:0] lb;
  } lights_t;

  // Decode a phase into the two street lamps. Codes 6/7 only exist for one
  // cycle before recovery; show all-red then, which is the safe choice.
  function automatic lights_t phase_lights(input phase_t p);
    lights_t l;
    l.la = RED;
    l.lb = RED;
    case (p)
      A_GREEN:  l.la = GREEN;
      A_YELLOW: l.la = YELLOW;
      B_GREEN:  l.lb = GREEN;
      B_YELLOW: l.lb = YELLOW;
      default: begin
        l.la = RED;
        l.lb = RED;
      end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Saturating tick counter measuring time spent in the current phase.
// Latency: count updates on the edge where tick (or clr) is sampled.
// Backpressure: none; clr has priority over tick, count holds at all-ones.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  // Clear on phase change, otherwise count ticks and stop at the top value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (tick && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Two-street phase scheduler: min/max green, yellow and all-red timed in ticks, with ped walk.
// Latency: a qualifying tick changes phase and lamps on that same edge (Moore outputs).
// Backpressure: none; tick=0 freezes phase and timer, ped requests are latched until served.
module traffic_phase_scheduler #(
  parameter int CNT_W      = 8,
  parameter int MIN_GREEN  = 8,
  parameter int MAX_GREEN  = 32,
  parameter int YELLOW_CYC = 4,
  parameter int ALLRED_CYC = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       TA,
  input  logic       TB,
  input  logic       ped_req_a,
  input  logic       ped_req_b,
  output logic [1:0] LA,
  output logic [1:0] LB,
  output logic       walk_a,
  output logic       walk_b,
  output logic [2:0] phase
);

  import traffic_pkg::*;

  localparam int DUR_MAX = 1 << CNT_W;

  // Reject parameter sets the timer cannot represent or that make no sense.
  if (CNT_W < 1 || CNT_W > 30 ||
      MIN_GREEN  < 1 || MIN_GREEN  > DUR_MAX ||
      MAX_GREEN  < 1 || MAX_GREEN  > DUR_MAX ||
      YELLOW_CYC < 1 || YELLOW_CYC > DUR_MAX ||
      ALLRED_CYC < 1 || ALLRED_CYC > DUR_MAX ||
      MIN_GREEN > MAX_GREEN) begin : g_bad_params
    $error("traffic_phase_scheduler: illegal duration parameters");
  end

  // Timer value seen on the tick that completes each interval.
  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(ALLRED_CYC - 1);

  phase_t           phase_q;
  phase_t           phase_d;
  logic [CNT_W-1:0] timer;
  logic             phase_chg;
  logic             demand_a;
  logic             demand_b;
  logic             pend_a;
  logic             pend_b;
  logic             serve_a;
  logic             serve_b;
  logic             enter_a;
  logic             enter_b;
  logic             leave_a;
  logic             leave_b;
  lights_t          lights;

  assign demand_a = TA | pend_a;
  assign demand_b = TB | pend_b;

  // Next-phase decision; only a tick may advance a legal phase, illegal codes recover at once.
  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      A_GREEN: begin
        if (tick && (timer >= MIN_LAST) && demand_b && (!TA || (timer >= MAX_LAST)))
          phase_d = A_YELLOW;
      end
      A_YELLOW: begin
        if (tick && (timer == YEL_LAST))
          phase_d = RED_AB;
      end
      RED_AB: begin
        if (tick && (timer == AR_LAST))
          phase_d = B_GREEN;
      end
      B_GREEN: begin
        if (tick && (timer >= MIN_LAST) && demand_a && (!TB || (timer >= MAX_LAST)))
          phase_d = B_YELLOW;
      end
      B_YELLOW: begin
        if (tick && (timer == YEL_LAST))
          phase_d = RED_BA;
      end
      RED_BA: begin
        if (tick && (timer == AR_LAST))
          phase_d = A_GREEN;
      end
      default: phase_d = A_GREEN;
    endcase
  end

  assign phase_chg = (phase_d != phase_q);
  assign enter_a   = phase_chg && (phase_d == A_GREEN);
  assign enter_b   = phase_chg && (phase_d == B_GREEN);
  assign leave_a   = phase_chg && (phase_q == A_GREEN);
  assign leave_b   = phase_chg && (phase_q == B_GREEN);

  // Phase register; reset parks the intersection on A green.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= A_GREEN;
    end else begin
      phase_q <= phase_d;
    end
  end

  // Time in phase; restarts from zero whenever the phase changes.
  phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .clr   (phase_chg),
    .count (timer)
  );

  // Pending requests: a new request wins over the clear on green entry, so a
  // press on that edge waits for the following green.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_a <= 1'b0;
      pend_b <= 1'b0;
    end else begin
      if (ped_req_a)
        pend_a <= 1'b1;
      else if (enter_a)
        pend_a <= 1'b0;
      if (ped_req_b)
        pend_b <= 1'b1;
      else if (enter_b)
        pend_b <= 1'b0;
    end
  end

  // Serve flags: snapshot of pending at green entry, dropped when that green ends.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      serve_a <= 1'b0;
      serve_b <= 1'b0;
    end else begin
      if (enter_a)
        serve_a <= pend_a;
      else if (leave_a)
        serve_a <= 1'b0;
      if (enter_b)
        serve_b <= pend_b;
      else if (leave_b)
        serve_b <= 1'b0;
    end
  end

  // Moore outputs decoded from registered state only.
  always_comb begin
    lights = phase_lights(phase_q);
    LA     = lights.la;
    LB     = lights.lb;
    walk_a = serve_a && (phase_q == A_GREEN);
    walk_b = serve_b && (phase_q == B_GREEN);
    phase  = phase_q;
  end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scoreboard bench: random and directed stimulus, street-level reference model, negedge monitor.
// Latency: expected outputs are pushed at each active edge and compared at the following falling edge.
// Backpressure: none; the DUT presents valid outputs every cycle.
module tb_traffic_phase_scheduler;

  localparam int MIN_G = 8;
  localparam int MAX_G = 32;
  localparam int YEL   = 4;
  localparam int AR    = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       TA = 1'b0;
  logic       TB = 1'b0;
  logic       ped_req_a = 1'b0;
  logic       ped_req_b = 1'b0;
  logic [1:0] LA;
  logic [1:0] LB;
  logic       walk_a;
  logic       walk_b;
  logic [2:0] phase;

  traffic_phase_scheduler #(
    .CNT_W(8), .MIN_GREEN(MIN_G), .MAX_GREEN(MAX_G), .YELLOW_CYC(YEL), .ALLRED_CYC(AR)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .TA(TA), .TB(TB),
    .ped_req_a(ped_req_a), .ped_req_b(ped_req_b),
    .LA(LA), .LB(LB), .walk_a(walk_a), .walk_b(walk_b), .phase(phase)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] la;
    logic [1:0] lb;
    logic       wa;
    logic       wb;
    logic [2:0] ph;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: which street owns the intersection, which stage of its
  // cycle (0 green, 1 yellow, 2 clearance) and how many ticks have elapsed.
  int m_street;
  int m_stage;
  int m_elapsed;
  bit m_pend[2];
  bit m_serve[2];

  function automatic void model_reset();
    m_street  = 0;
    m_stage   = 0;
    m_elapsed = 0;
    m_pend[0] = 0; m_pend[1] = 0;
    m_serve[0] = 0; m_serve[1] = 0;
  endfunction

  function automatic void model_step(bit t, bit ta, bit tb, bit pa, bit pb);
    bit veh[2];
    int now;
    int other;
    bit leave;
    veh[0] = ta;
    veh[1] = tb;
    other  = 1 - m_street;
    if (t) begin
      now = m_elapsed + 1;
      if (m_stage == 0)
        leave = (now >= MIN_G) && (veh[other] || m_pend[other]) && (!veh[m_street] || now >= MAX_G);
      else if (m_stage == 1)
        leave = (now == YEL);
      else
        leave = (now == AR);
      if (leave) begin
        if (m_stage == 0) m_serve[m_street] = 0;
        m_stage   = m_stage + 1;
        m_elapsed = 0;
        if (m_stage == 3) begin
          m_stage         = 0;
          m_street        = other;
          m_serve[other]  = m_pend[other];
          m_pend[other]   = 0;
        end
      end else begin
        m_elapsed = now;
      end
    end
    if (pa) m_pend[0] = 1;
    if (pb) m_pend[1] = 1;
  endfunction

  function automatic obs_t model_out();
    obs_t o;
    // Owner street shows green/yellow/red by stage (00/01/10); the other street is red.
    o.la = (m_street == 0) ? 2'(m_stage) : 2'b10;
    o.lb = (m_street == 1) ? 2'(m_stage) : 2'b10;
    o.wa = m_serve[0] && m_street == 0 && m_stage == 0;
    o.wb = m_serve[1] && m_street == 1 && m_stage == 0;
    o.ph = 3'(m_street * 3 + m_stage);
    return o;
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: every falling edge, pair the DUT outputs with the oldest expectation.
  initial begin
    obs_t e;
    obs_t a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {LA, LB, walk_a, walk_b, phase};
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL scoreboard: got LA=%b LB=%b wa=%b wb=%b ph=%0d, required LA=%b LB=%b wa=%b wb=%b ph=%0d at %0t",
                   a.la, a.lb, a.wa, a.wb, a.ph, e.la, e.lb, e.wa, e.wb, e.ph, $time);
        end
      end
    end
  end

  // One clock of stimulus: drive, let the edge happen, record the expectation.
  task automatic step(input bit t, input bit ta, input bit tb, input bit pa, input bit pb);
    tick = t; TA = ta; TB = tb; ped_req_a = pa; ped_req_b = pb;
    @(posedge clk);
    if (reset) model_reset();
    else model_step(t, ta, tb, pa, pb);
    exp_q.push_back(model_out());
    #1;
  endtask

  task automatic run(input int n, input bit t, input bit ta, input bit tb);
    for (int i = 0; i < n; i++) step(t, ta, tb, 1'b0, 1'b0);
  endtask

  // Reset asserted between edges, optionally checking the outputs respond before any edge.
  task automatic do_reset(input bit check_now);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    if (check_now) begin
      chk("async_rst_LA", LA, 0);
      chk("async_rst_LB", LB, 2);
      chk("async_rst_walk_a", walk_a, 0);
      chk("async_rst_walk_b", walk_b, 0);
      chk("async_rst_phase", phase, 0);
    end
    model_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    int tick_pct;
    int ped_pct;
    bit ta_r;
    bit tb_r;

    // Reset state and A holding green with no B demand.
    do_reset(1'b1);
    run(100, 1'b1, 1'b1, 1'b0);
    chk("hold_phase", phase, 0);
    chk("hold_LA", LA, 0);

    // Uncontested B demand: yellow after edge 8, all red after 12, B green after 14.
    do_reset(1'b0);
    for (int k = 1; k <= 14; k++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      if (k == 7)  chk("minG_LA_e7", LA, 0);
      if (k == 8)  chk("minG_LA_e8", LA, 1);
      if (k == 12) chk("allred_LA_e12", LA, 2);
      if (k == 12) chk("allred_LB_e12", LB, 2);
      if (k == 13) chk("allred_LB_e13", LB, 2);
      if (k == 14) chk("bgreen_LB_e14", LB, 0);
      if (k == 14) chk("bgreen_ph_e14", phase, 3);
    end

    // Both contested: A yields at max green, B likewise.
    do_reset(1'b0);
    for (int k = 1; k <= 72; k++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      if (k == 31) chk("maxG_LA_e31", LA, 0);
      if (k == 32) chk("maxG_LA_e32", LA, 1);
      if (k == 38) chk("maxG_LB_e38", LB, 0);
      if (k == 69) chk("maxG_LB_e69", LB, 0);
      if (k == 70) chk("maxG_LB_e70", LB, 1);
    end

    // Pedestrian request for B with no B vehicle.
    do_reset(1'b0);
    for (int k = 1; k <= 48; k++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, k == 3);
      if (k == 38) chk("ped_walk_b_e38", walk_b, 1);
      if (k == 38) chk("ped_ph_e38", phase, 3);
      if (k == 45) chk("ped_walk_b_e45", walk_b, 1);
      if (k == 46) chk("ped_walk_b_e46", walk_b, 0);
      if (k == 46) chk("ped_LB_e46", LB, 1);
    end

    // Tick stall in the middle of A yellow.
    do_reset(1'b0);
    run(10, 1'b1, 1'b0, 1'b1);
    run(20, 1'b0, 1'b0, 1'b1);
    chk("stall_LA", LA, 1);
    run(1, 1'b1, 1'b0, 1'b1);
    chk("stall_resume_LA", LA, 1);
    run(1, 1'b1, 1'b0, 1'b1);
    chk("stall_done_LA", LA, 2);
    run(6, 1'b1, 1'b0, 1'b1);

    // Reset during B yellow with an A ped request pending, then A holds.
    do_reset(1'b0);
    run(14, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    run(8, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_LB", LB, 1);
    do_reset(1'b1);
    run(60, 1'b1, 1'b1, 1'b0);
    chk("post_rst_walk_a", walk_a, 0);

    // Randomized traffic: varied tick density, sticky vehicle sensors, sparse peds.
    for (int s = 0; s < 12; s++) begin
      tick_pct = $urandom_range(100, 25);
      ped_pct  = $urandom_range(8, 0);
      ta_r = $urandom_range(1, 0);
      tb_r = $urandom_range(1, 0);
      for (int c = 0; c < 220; c++) begin
        if ($urandom_range(99, 0) < 8) ta_r = ~ta_r;
        if ($urandom_range(99, 0) < 8) tb_r = ~tb_r;
        step($urandom_range(99, 0) < tick_pct, ta_r, tb_r,
             $urandom_range(99, 0) < ped_pct, $urandom_range(99, 0) < ped_pct);
      end
      if ($urandom_range(3, 0) == 0) do_reset(1'b1);
    end

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
